alu_nibble_sequencer: RTL and testbench
=======================================

// Module: alu_nibble_sequencer
// PURPOSE
// - Runs WIDTH-bit operations on one external 4-bit 74181-style ALU, one nibble per cycle, LSB nibble first.
// - Carry ripples between nibbles through a carry register.
// - Sits between a requester (op valid/ready) and the combinational ALU instance: it drives S/M/Cn/A/B and captures F/carry.
// PARAMETERS
// - WIDTH  16  operand/result width; must be a multiple of 4 and >= 8 (elaboration $error otherwise)
// - NIBBLES = WIDTH/4 is a localparam, not user-settable.
// PORTS
// - clk_i            in   1      single clock; all state updates on rising edge
// - rst_ni           in   1      reset: synchronous, active-low
// - op_valid_i       in   1      request valid
// - op_ready_o       out  1      request accepted when op_valid_i && op_ready_o
// - op_s_i           in   4      ALU function select, captured at accept
// - op_m_i           in   1      1 = logic mode, 0 = arithmetic mode; captured at accept
// - op_carry_i       in   1      carry into nibble 0 (active-high, 1 = +1); captured at accept
// - op_a_i           in   WIDTH  operand A, captured at accept
// - op_b_i           in   WIDTH  operand B, captured at accept
// - res_valid_o      out  1      result valid
// - res_ready_i      in   1      result consumed when res_valid_o && res_ready_i
// - res_f_o          out  WIDTH  result
// - res_carry_o      out  1      carry out of the top nibble (arithmetic mode), 0 in logic mode
// - alu_s_o          out  4      to ALU S select
// - alu_m_o          out  1      to ALU mode control
// - alu_cn_o         out  1      to ALU carry in (active-high)
// - alu_a_o          out  4      to ALU A nibble
// - alu_b_o          out  4      to ALU B nibble
// - alu_f_i          in   4      from ALU F (combinational, same cycle)
// - alu_carry_i      in   1      from ALU carry-plus-four (active-high)
// - alu_eq_i         in   1      from ALU equality output
// BEHAVIOUR
// - FSM states: IDLE, RUN, DONE. A nibble counter idx runs 0..NIBBLES-1.
// - Reset (rst_ni low at an edge):
//   - state=IDLE, idx=0.
//   - res_f_o=0, res_carry_o=0, res_valid_o=0, all captured operands/flags cleared.
// - IDLE:
//   - op_ready_o=1. On accept: latch s/m/carry/a/b, idx<=0, go to RUN.
//   - ALU ports idle at s=0, m=1, cn=0, a=0, b=0.
// - RUN: op_ready_o=0, res_valid_o=0.
//   - Drive alu_a_o/alu_b_o = nibble idx of latched A/B; alu_s_o/alu_m_o = latched s/m.
//   - alu_cn_o = latched op_carry for idx 0, else the carry register.
//   - At each edge: res_f_o[4*idx+:4] <= alu_f_i; carry register <= alu_carry_i; idx++.
//   - After idx = NIBBLES-1, go to DONE.
// - DONE:
//   - res_valid_o=1; res_f_o and res_carry_o are held stable.
//   - op_valid_i is ignored. On res_ready_i, go to IDLE.
//   - A new accept is possible no earlier than the next cycle.
// - Latency: res_valid_o rises NIBBLES edges after the accepting edge (4 for WIDTH=16). Throughput: one op per NIBBLES+2 cycles.
// - Logic mode (latched m=1):
//   - alu_cn_o = latched op_carry for every nibble.
//   - Inter-nibble carry is not propagated; res_carry_o=0.
// - Arithmetic mode: res_carry_o = alu_carry_i captured on the last nibble.
// - Reset asserted mid-RUN or DONE: the op is aborted, no result is produced, and the FSM is in IDLE on the next cycle.
// - No X may appear on any output after the first reset edge.
// CONFIGURATION
// - ALU_SEQ_FLAGS_EN defined:
//   - Adds outputs res_zero_o (1 when res_f_o==0) and res_eq_o (AND of alu_eq_i sampled on every nibble).
//   - Both are registered and valid with res_valid_o; reset value 0.
// - ALU_SEQ_FLAGS_EN undefined: neither port nor its logic exists. All other behaviour is identical.
// TESTING
// - Arithmetic add: S=1001 M=0 cn=0, A=0x1234 B=0x0FCF.
//   - Response: res_f=0x2203, carry=0, res_valid 4 cycles after accept.
// - Add with overflow: S=1001 M=0 cn=0, A=0xFFFF B=0x0001.
//   - Response: res_f=0x0000, carry=1; alu_cn_o=1 on nibbles 1..3.
// - Subtract: S=0110 M=0 cn=1, A=0x5000 B=0x0001.
//   - Response: res_f=0x4FFF, carry=1 (no borrow).
// - Logic XOR: S=0110 M=1, A=0xA5A5 B=0xFFFF.
//   - Response: res_f=0x5A5A, carry=0; alu_cn_o constant.
// - Backpressure: hold res_ready_i=0 for 3 cycles in DONE with op_valid_i=1.
//   - Response: result stable, op_ready_o=0, no op accepted; IDLE after res_ready_i.
// - Reset mid-RUN after nibble 1: rst_ni=0 for one edge.
//   - Response: res_valid_o never rises for that op; next op 0x0001+0x0001 gives 0x0002.

Source files
------------

// File: rtl/alu_nibble_sequencer_if.sv
// Request/result bus between a requester and alu_nibble_sequencer.
// master: requester side (drives op_*, res_ready_i); slave: sequencer side.
// Signals: op_valid_i/op_ready_o handshake with op_s_i, op_m_i, op_carry_i,
// op_a_i, op_b_i payload; res_valid_o/res_ready_i handshake with res_f_o,
// res_carry_o payload. With ALU_SEQ_FLAGS_EN defined, res_zero_o and
// res_eq_o are added to the result payload.
interface alu_nibble_sequencer_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             op_valid_i;
  logic             op_ready_o;
  logic [3:0]       op_s_i;
  logic             op_m_i;
  logic             op_carry_i;
  logic [WIDTH-1:0] op_a_i;
  logic [WIDTH-1:0] op_b_i;
  logic             res_valid_o;
  logic             res_ready_i;
  logic [WIDTH-1:0] res_f_o;
  logic             res_carry_o;
`ifdef ALU_SEQ_FLAGS_EN
  logic             res_zero_o;
  logic             res_eq_o;
`endif

  modport master (
    output op_valid_i, op_s_i, op_m_i, op_carry_i, op_a_i, op_b_i, res_ready_i,
    input  op_ready_o, res_valid_o, res_f_o, res_carry_o
`ifdef ALU_SEQ_FLAGS_EN
    , input res_zero_o, res_eq_o
`endif
  );

  modport slave (
    input  op_valid_i, op_s_i, op_m_i, op_carry_i, op_a_i, op_b_i, res_ready_i,
    output op_ready_o, res_valid_o, res_f_o, res_carry_o
`ifdef ALU_SEQ_FLAGS_EN
    , output res_zero_o, res_eq_o
`endif
  );
endinterface

// File: rtl/alu_nibble_sequencer.sv
// Runs WIDTH-bit operations on one external 4-bit 74181-style ALU, one nibble
// per cycle, LSB nibble first, rippling carry through a register.
// Ports:
//   clk_i, rst_ni       clock, synchronous active-low reset
//   bus (slave)         op request handshake/payload and result handshake/payload
//   alu_s_o/m_o/cn_o    function select, mode, carry in (active-high) to the ALU
//   alu_a_o/alu_b_o     operand nibbles to the ALU
//   alu_f_i/carry_i/eq_i  combinational ALU result, carry-plus-four, A=B output
// Optional feature macro: ALU_SEQ_FLAGS_EN adds res_zero_o/res_eq_o on the bus.
module alu_nibble_sequencer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  alu_nibble_sequencer_if.slave bus,
  output logic [3:0]           alu_s_o,
  output logic                 alu_m_o,
  output logic                 alu_cn_o,
  output logic [3:0]           alu_a_o,
  output logic [3:0]           alu_b_o,
  input  logic [3:0]           alu_f_i,
  input  logic                 alu_carry_i,
  input  logic                 alu_eq_i
);
  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  if (((WIDTH % 4) != 0) || (WIDTH < 8)) begin : g_width_check
    $error("alu_nibble_sequencer: WIDTH must be a multiple of 4 and >= 8");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [WIDTH-1:0]   a_sh_q;
  logic [WIDTH-1:0]   b_sh_q;
  logic [3:0]         s_q;
  logic               m_q;
  logic               cn_q;
  logic               carry_in_q;
  logic [WIDTH-1:0]   res_f_q;
  logic               res_carry_q;
  logic               ready_q;
  logic               valid_q;
  logic [WIDTH-1:0]   res_next;
  logic               last_nibble;
`ifdef ALU_SEQ_FLAGS_EN
  logic               zero_q;
  logic               eq_q;
`else
  logic               unused_eq;
  assign unused_eq = alu_eq_i;
`endif

  // Result fills from the top so nibble 0 lands at the bottom after NIBBLES shifts.
  assign res_next    = {alu_f_i, res_f_q[WIDTH-1:4]};
  assign last_nibble = (idx_q == IDX_W'(NIBBLES - 1));

  // Sequencer FSM; operand shift registers present the current nibble at [3:0].
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      s_q         <= 4'd0;
      m_q         <= 1'b1;
      cn_q        <= 1'b0;
      carry_in_q  <= 1'b0;
      res_f_q     <= '0;
      res_carry_q <= 1'b0;
      ready_q     <= 1'b1;
      valid_q     <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
      zero_q      <= 1'b0;
      eq_q        <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.op_valid_i) begin
            state_q    <= RUN;
            idx_q      <= '0;
            a_sh_q     <= bus.op_a_i;
            b_sh_q     <= bus.op_b_i;
            s_q        <= bus.op_s_i;
            m_q        <= bus.op_m_i;
            cn_q       <= bus.op_carry_i;
            carry_in_q <= bus.op_carry_i;
            ready_q    <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
            eq_q       <= 1'b1;
`endif
          end
        end
        RUN: begin
          res_f_q <= res_next;
          a_sh_q  <= {4'd0, a_sh_q[WIDTH-1:4]};
          b_sh_q  <= {4'd0, b_sh_q[WIDTH-1:4]};
          // Logic mode re-applies the latched carry to every nibble.
          cn_q    <= m_q ? carry_in_q : alu_carry_i;
          idx_q   <= idx_q + IDX_W'(1);
`ifdef ALU_SEQ_FLAGS_EN
          eq_q    <= eq_q & alu_eq_i;
`endif
          if (last_nibble) begin
            state_q     <= DONE;
            idx_q       <= '0;
            valid_q     <= 1'b1;
            res_carry_q <= m_q ? 1'b0 : alu_carry_i;
            // Park the ALU controls at their idle values while not running.
            s_q         <= 4'd0;
            m_q         <= 1'b1;
            cn_q        <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
            zero_q      <= (res_next == '0);
`endif
          end
        end
        DONE: begin
          if (bus.res_ready_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.op_ready_o  = ready_q;
  assign bus.res_valid_o = valid_q;
  assign bus.res_f_o     = res_f_q;
  assign bus.res_carry_o = res_carry_q;
`ifdef ALU_SEQ_FLAGS_EN
  assign bus.res_zero_o  = zero_q;
  assign bus.res_eq_o    = eq_q;
`endif
  assign alu_s_o  = s_q;
  assign alu_m_o  = m_q;
  assign alu_cn_o = cn_q;
  assign alu_a_o  = a_sh_q[3:0];
  assign alu_b_o  = b_sh_q[3:0];
endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Self-checking bench for alu_nibble_sequencer with a behavioural 4-bit
// 74181-style ALU attached and a full-width function-table reference model.
module tb_alu_nibble_sequencer;
  localparam int unsigned WIDTH   = 16;
  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned W1      = WIDTH + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_nibble_sequencer_if #(.WIDTH(WIDTH)) bus ();

  logic [3:0] alu_s, alu_a, alu_b, alu_f;
  logic       alu_m, alu_cn, alu_carry, alu_eq;

  alu_nibble_sequencer #(.WIDTH(WIDTH)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bus         (bus),
    .alu_s_o     (alu_s),
    .alu_m_o     (alu_m),
    .alu_cn_o    (alu_cn),
    .alu_a_o     (alu_a),
    .alu_b_o     (alu_b),
    .alu_f_i     (alu_f),
    .alu_carry_i (alu_carry),
    .alu_eq_i    (alu_eq)
  );

  // Behavioural 4-bit ALU: arithmetic F = X + Y + Cn, logic F = ~(X ^ Y).
  logic [3:0] x_n, y_n;
  logic [4:0] sum_n;
  always_comb begin
    x_n   = alu_a | (alu_b & {4{alu_s[0]}}) | (~alu_b & {4{alu_s[1]}});
    y_n   = (alu_a & alu_b & {4{alu_s[3]}}) | (alu_a & ~alu_b & {4{alu_s[2]}});
    sum_n = {1'b0, x_n} + {1'b0, y_n} + 5'(alu_cn);
    alu_f     = alu_m ? ~(x_n ^ y_n) : sum_n[3:0];
    alu_carry = sum_n[4];
    alu_eq    = (alu_f == 4'hF);
  end

  int checks = 0;
  int errors = 0;

  // Reference: named 74181 functions on the whole word, carries from sum ^ t1 ^ t2.
  task automatic ref_op(input logic [3:0] s, input logic m, input logic cn,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        output logic [WIDTH-1:0] f, output logic c,
                        output logic [NIBBLES-1:0] cn_tr);
    logic [WIDTH-1:0] t1, t2, ones;
    logic [WIDTH:0]   sum;
    ones = '1;
    case (s)
      4'h0: begin t1 = a;        t2 = '0;     end
      4'h1: begin t1 = a | b;    t2 = '0;     end
      4'h2: begin t1 = a | ~b;   t2 = '0;     end
      4'h3: begin t1 = ones;     t2 = '0;     end
      4'h4: begin t1 = a;        t2 = a & ~b; end
      4'h5: begin t1 = a | b;    t2 = a & ~b; end
      4'h6: begin t1 = a;        t2 = ~b;     end
      4'h7: begin t1 = ones;     t2 = a & ~b; end
      4'h8: begin t1 = a;        t2 = a & b;  end
      4'h9: begin t1 = a;        t2 = b;      end
      4'hA: begin t1 = a | ~b;   t2 = a & b;  end
      4'hB: begin t1 = ones;     t2 = a & b;  end
      4'hC: begin t1 = a;        t2 = a;      end
      4'hD: begin t1 = a | b;    t2 = a;      end
      4'hE: begin t1 = a | ~b;   t2 = a;      end
      default: begin t1 = ones;  t2 = a;      end
    endcase
    sum = {1'b0, t1} + {1'b0, t2} + W1'(cn);
    if (m) begin
      case (s)
        4'h0: f = ~a;        4'h1: f = ~(a | b);  4'h2: f = ~a & b;   4'h3: f = '0;
        4'h4: f = ~(a & b);  4'h5: f = ~b;        4'h6: f = a ^ b;    4'h7: f = a & ~b;
        4'h8: f = ~a | b;    4'h9: f = ~(a ^ b);  4'hA: f = b;        4'hB: f = a & b;
        4'hC: f = ones;      4'hD: f = a | ~b;    4'hE: f = a | b;    default: f = a;
      endcase
      c = 1'b0;
      cn_tr = {NIBBLES{cn}};
    end else begin
      f = sum[WIDTH-1:0];
      c = sum[WIDTH];
      cn_tr[0] = cn;
      for (int k = 1; k < int'(NIBBLES); k++)
        cn_tr[k] = sum[4*k] ^ t1[4*k] ^ t2[4*k];
    end
  endtask

  // Drives one op, records alu_cn_o per RUN cycle, latency and result, then consumes it.
  task automatic do_op(input logic [3:0] s, input logic m, input logic cn,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       output logic [WIDTH-1:0] f, output logic c, output int lat,
                       output logic [NIBBLES-1:0] cn_tr, output logic zf, output logic ef);
    int w;
    w = 0;
    while (!bus.op_ready_o && w < 20) begin @(posedge clk); #1; w++; end
    bus.op_valid_i = 1'b1; bus.op_s_i = s; bus.op_m_i = m; bus.op_carry_i = cn;
    bus.op_a_i = a; bus.op_b_i = b;
    @(posedge clk); #1;
    bus.op_valid_i = 1'b0;
    lat = 0;
    cn_tr = '0;
    while (!bus.res_valid_o && lat < 20) begin
      if (lat < int'(NIBBLES)) cn_tr[lat] = alu_cn;
      @(posedge clk); #1;
      lat++;
    end
    f = bus.res_f_o;
    c = bus.res_carry_o;
`ifdef ALU_SEQ_FLAGS_EN
    zf = bus.res_zero_o;
    ef = bus.res_eq_o;
`else
    zf = 1'b0;
    ef = 1'b0;
`endif
    bus.res_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.res_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.op_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus.op_ready_o); end
    checks++; if (bus.res_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.res_valid_o); end
    checks++; if (bus.res_f_o !== '0) begin errors++; $display("FAIL reset_f got %h exp 0", bus.res_f_o); end
    checks++; if (bus.res_carry_o !== 1'b0) begin errors++; $display("FAIL reset_carry got %b exp 0", bus.res_carry_o); end
    checks++;
    if ({alu_s, alu_m, alu_cn, alu_a, alu_b} !== {4'h0, 1'b1, 1'b0, 4'h0, 4'h0}) begin
      errors++; $display("FAIL reset_alu_idle got s=%h m=%b cn=%b a=%h b=%h", alu_s, alu_m, alu_cn, alu_a, alu_b);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [3:0] s_v [4] = '{4'b1001, 4'b1001, 4'b0110, 4'b0110};
    logic       m_v [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic       c_v [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [WIDTH-1:0] a_v [4] = '{16'h1234, 16'hFFFF, 16'h5000, 16'hA5A5};
    logic [WIDTH-1:0] b_v [4] = '{16'h0FCF, 16'h0001, 16'h0001, 16'hFFFF};
    logic [WIDTH-1:0] f_e [4] = '{16'h2203, 16'h0000, 16'h4FFF, 16'h5A5A};
    logic             ce  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [WIDTH-1:0] f;
    logic c, zf, ef;
    int lat;
    logic [NIBBLES-1:0] tr;
    for (int i = 0; i < 4; i++) begin
      do_op(s_v[i], m_v[i], c_v[i], a_v[i], b_v[i], f, c, lat, tr, zf, ef);
      checks++; if (f !== f_e[i]) begin errors++; $display("FAIL dir_f[%0d] got %h exp %h", i, f, f_e[i]); end
      checks++; if (c !== ce[i]) begin errors++; $display("FAIL dir_carry[%0d] got %b exp %b", i, c, ce[i]); end
      checks++; if (lat != int'(NIBBLES)) begin errors++; $display("FAIL dir_latency[%0d] got %0d exp %0d", i, lat, NIBBLES); end
    end
    // Overflow case: carry ripples into nibbles 1..3.
    do_op(4'b1001, 1'b0, 1'b0, 16'hFFFF, 16'h0001, f, c, lat, tr, zf, ef);
    checks++; if (tr !== 4'b1110) begin errors++; $display("FAIL dir_ovf_cn got %b exp 1110", tr); end
    // Logic mode with carry-in 1: cn stays constant, no carry out.
    do_op(4'b0110, 1'b1, 1'b1, 16'hA5A5, 16'hFFFF, f, c, lat, tr, zf, ef);
    checks++; if (tr !== 4'b1111) begin errors++; $display("FAIL dir_logic_cn got %b exp 1111", tr); end
    checks++; if (c !== 1'b0) begin errors++; $display("FAIL dir_logic_carry got %b exp 0", c); end
  endtask

  task automatic test_random();
    logic [3:0] s;
    logic m, cn, c, ce, zf, ef;
    logic [WIDTH-1:0] a, b, f, fe;
    logic [NIBBLES-1:0] tr, tre;
    int lat;
    for (int i = 0; i < 40; i++) begin
      s  = 4'($urandom_range(0, 15));
      m  = 1'($urandom_range(0, 1));
      cn = 1'($urandom_range(0, 1));
      a  = WIDTH'($urandom);
      b  = (i % 8 == 3) ? ~a : WIDTH'($urandom);
      ref_op(s, m, cn, a, b, fe, ce, tre);
      do_op(s, m, cn, a, b, f, c, lat, tr, zf, ef);
      checks++; if (f !== fe) begin errors++; $display("FAIL rand_f[%0d] s=%h m=%b got %h exp %h", i, s, m, f, fe); end
      checks++; if (c !== ce) begin errors++; $display("FAIL rand_carry[%0d] got %b exp %b", i, c, ce); end
      checks++; if (tr !== tre) begin errors++; $display("FAIL rand_cn[%0d] got %b exp %b", i, tr, tre); end
      checks++; if (lat != int'(NIBBLES)) begin errors++; $display("FAIL rand_latency[%0d] got %0d exp %0d", i, lat, NIBBLES); end
`ifdef ALU_SEQ_FLAGS_EN
      checks++; if (zf !== (fe == '0)) begin errors++; $display("FAIL rand_zero[%0d] got %b exp %b", i, zf, (fe == '0)); end
      checks++; if (ef !== (fe == '1)) begin errors++; $display("FAIL rand_eq[%0d] got %b exp %b", i, ef, (fe == '1)); end
`endif
    end
  endtask

  task automatic test_backpressure();
    int w;
    w = 0;
    while (!bus.op_ready_o && w < 20) begin @(posedge clk); #1; w++; end
    bus.op_valid_i = 1'b1; bus.op_s_i = 4'b1001; bus.op_m_i = 1'b0; bus.op_carry_i = 1'b0;
    bus.op_a_i = 16'h1111; bus.op_b_i = 16'h2222;
    @(posedge clk); #1;
    bus.op_a_i = 16'h7777; bus.op_b_i = 16'h7777;
    w = 0;
    while (!bus.res_valid_o && w < 20) begin @(posedge clk); #1; w++; end
    checks++; if (bus.res_valid_o !== 1'b1) begin errors++; $display("FAIL bp_valid_timeout got %b exp 1", bus.res_valid_o); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.res_f_o !== 16'h3333) begin errors++; $display("FAIL bp_f[%0d] got %h exp 3333", i, bus.res_f_o); end
      checks++; if (bus.op_ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got %b exp 0", i, bus.op_ready_o); end
      checks++; if (bus.res_valid_o !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d] got %b exp 1", i, bus.res_valid_o); end
      @(posedge clk); #1;
    end
    bus.res_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.res_ready_i = 1'b0;
    bus.op_valid_i = 1'b0;
    checks++; if (bus.op_ready_o !== 1'b1) begin errors++; $display("FAIL bp_idle_ready got %b exp 1", bus.op_ready_o); end
    checks++; if (bus.res_valid_o !== 1'b0) begin errors++; $display("FAIL bp_idle_valid got %b exp 0", bus.res_valid_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    int w;
    logic seen;
    logic [WIDTH-1:0] f;
    logic c, zf, ef;
    int lat;
    logic [NIBBLES-1:0] tr;
    w = 0;
    while (!bus.op_ready_o && w < 20) begin @(posedge clk); #1; w++; end
    bus.op_valid_i = 1'b1; bus.op_s_i = 4'b1001; bus.op_m_i = 1'b0; bus.op_carry_i = 1'b0;
    bus.op_a_i = 16'h1234; bus.op_b_i = 16'h4321;
    @(posedge clk); #1;
    bus.op_valid_i = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if (bus.op_ready_o !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %b exp 1", bus.op_ready_o); end
    checks++; if (bus.res_f_o !== '0) begin errors++; $display("FAIL rst_mid_f got %h exp 0", bus.res_f_o); end
    checks++; if (alu_m !== 1'b1 || alu_a !== 4'h0) begin errors++; $display("FAIL rst_mid_alu got m=%b a=%h exp m=1 a=0", alu_m, alu_a); end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.res_valid_o !== 1'b0) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_mid_no_result got %b exp 0", seen); end
    do_op(4'b1001, 1'b0, 1'b0, 16'h0001, 16'h0001, f, c, lat, tr, zf, ef);
    checks++; if (f !== 16'h0002) begin errors++; $display("FAIL rst_mid_next_f got %h exp 0002", f); end
  endtask

  task automatic test_back_to_back();
    int acc [$];
    int results;
    logic idle_bad;
    bus.op_s_i = 4'b1001; bus.op_m_i = 1'b0; bus.op_carry_i = 1'b0;
    bus.op_a_i = 16'h0003; bus.op_b_i = 16'h0004;
    bus.op_valid_i = 1'b1;
    bus.res_ready_i = 1'b1;
    results = 0;
    idle_bad = 1'b0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      if (bus.op_ready_o === 1'b1) begin
        acc.push_back(cyc);
        if ({alu_s, alu_m, alu_cn, alu_a, alu_b} !== {4'h0, 1'b1, 1'b0, 4'h0, 4'h0}) idle_bad = 1'b1;
      end
      if (bus.res_valid_o === 1'b1) begin
        results++;
        checks++; if (bus.res_f_o !== 16'h0007) begin errors++; $display("FAIL b2b_f got %h exp 0007", bus.res_f_o); end
      end
      @(posedge clk); #1;
    end
    bus.op_valid_i = 1'b0;
    checks++; if (idle_bad !== 1'b0) begin errors++; $display("FAIL b2b_alu_idle got %b exp 0", idle_bad); end
    checks++;
    if (acc.size() < 2 || (acc[1] - acc[0]) != int'(NIBBLES + 2)) begin
      errors++; $display("FAIL b2b_spacing got %0d accepts, gap %0d exp %0d", acc.size(),
                         (acc.size() >= 2) ? acc[1] - acc[0] : -1, NIBBLES + 2);
    end
    checks++; if (results < 2) begin errors++; $display("FAIL b2b_results got %0d exp >=2", results); end
    for (int w = 0; w < 20 && bus.op_ready_o !== 1'b1; w++) begin @(posedge clk); #1; end
    bus.res_ready_i = 1'b0;
  endtask

  initial begin
    bus.op_valid_i  = 1'b0;
    bus.op_s_i      = 4'h0;
    bus.op_m_i      = 1'b0;
    bus.op_carry_i  = 1'b0;
    bus.op_a_i      = '0;
    bus.op_b_i      = '0;
    bus.res_ready_i = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
